// File: rtl/hc595_pkg.sv
// rtl/hc595_pkg.sv - shared types and defaults for the 74HC595-style serial bus
package hc595_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_BITS        = 16;
    localparam int DEF_TIMEOUT     = 1024;
    localparam int DEF_SYNC_STAGES = 2;
    // SHCP/STCP high and low times, in Clk cycles, the receiver can resolve
    localparam int MIN_PULSE_CLK   = 3;

endpackage

// File: rtl/hc595_rx_if.sv
// rtl/hc595_rx_if.sv - 3-wire 595 bus pins plus receiver result signals
import hc595_pkg::*;

interface hc595_rx_if #(
    parameter int BITS = DEF_BITS
);
    logic            SHCP;
    logic            STCP;
    logic            DS;
    logic [BITS-1:0] Data_out;
    logic            Data_valid;
    logic            Frame_err;
    logic            Timeout;
    logic            Busy;

    modport master (
        output SHCP, STCP, DS,
        input  Data_out, Data_valid, Frame_err, Timeout, Busy
    );

    modport slave (
        input  SHCP, STCP, DS,
        output Data_out, Data_valid, Frame_err, Timeout, Busy
    );
endinterface

// File: rtl/hc595_rx_sync_edge_det.sv
// rtl/hc595_rx_sync_edge_det.sv - multi-flop pin synchroniser with rising-edge pulse
import hc595_pkg::*;

module sync_edge_det #(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
endmodule

// File: rtl/hc595_rx.sv
// rtl/hc595_rx.sv - 595-style serial receiver: shift on SHCP, latch on STCP, frame checks
import hc595_pkg::*;

module hc595_rx #(
    parameter int BITS        = DEF_BITS,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       Clk,
    input  logic       Reset_n,
    hc595_rx_if.slave  bus
);
    localparam int CNT_W  = $clog2(BITS + 2);
    localparam int IDLE_W = $clog2(TIMEOUT);

    logic w_shcp_rise, w_stcp_rise, w_ds;
    logic w_shcp_level_unused, w_stcp_level_unused, w_ds_rise_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_shcp (
        .i_clk(Clk), .i_reset_n(Reset_n), .i_pin(bus.SHCP),
        .o_level(w_shcp_level_unused), .o_rise(w_shcp_rise));
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_stcp (
        .i_clk(Clk), .i_reset_n(Reset_n), .i_pin(bus.STCP),
        .o_level(w_stcp_level_unused), .o_rise(w_stcp_rise));
    // DS shares SHCP's depth so the sampled bit lines up with the detected rise
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_ds (
        .i_clk(Clk), .i_reset_n(Reset_n), .i_pin(bus.DS),
        .o_level(w_ds), .o_rise(w_ds_rise_unused));

    state_t              r_state, w_state_nxt;
    logic [BITS-1:0]     r_shift_reg, w_shift_nxt;
    logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [IDLE_W-1:0]   r_idle_cnt, w_idle_nxt;
    logic [BITS-1:0]     r_data_out, w_data_out_nxt;
    logic                r_data_valid, w_dv_nxt;
    logic                r_frame_err, w_ferr_nxt;
    logic                r_timeout, w_to_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_shift_reg  <= '0;
            r_bit_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift_reg  <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_idle_cnt   <= w_idle_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_dv_nxt;
            r_frame_err  <= w_ferr_nxt;
            r_timeout    <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift_reg;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_idle_nxt     = r_idle_cnt;
        w_data_out_nxt = r_data_out;
        w_dv_nxt       = 1'b0;
        w_ferr_nxt     = r_frame_err;
        w_to_nxt       = 1'b0;

        if (w_shcp_rise)
            w_shift_nxt = {r_shift_reg[BITS-2:0], w_ds};

        case (r_state)
            IDLE: begin
                w_idle_nxt = '0;
                if (w_stcp_rise) begin
                    w_data_out_nxt = r_shift_reg;
                    w_dv_nxt       = 1'b1;
                    w_ferr_nxt     = 1'b1;
                end
                if (w_shcp_rise) begin
                    w_bit_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (w_shcp_rise) begin
                    w_idle_nxt = '0;
                    if (r_bit_cnt != CNT_W'(BITS + 1))
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end else begin
                    w_idle_nxt = r_idle_cnt + IDLE_W'(1);
                end
                // A latch on the same cycle as a shift reports the pre-shift frame; the new bit opens the next one
                if (w_stcp_rise) begin
                    w_data_out_nxt = r_shift_reg;
                    w_dv_nxt       = 1'b1;
                    w_ferr_nxt     = (r_bit_cnt != CNT_W'(BITS));
                    w_idle_nxt     = '0;
                    w_bit_cnt_nxt  = w_shcp_rise ? CNT_W'(1) : '0;
                    w_state_nxt    = w_shcp_rise ? SHIFT : IDLE;
                end else if (!w_shcp_rise && r_idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    w_to_nxt      = 1'b1;
                    w_idle_nxt    = '0;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.Data_out   = r_data_out;
    assign bus.Data_valid = r_data_valid;
    assign bus.Frame_err  = r_frame_err;
    assign bus.Timeout    = r_timeout;
    assign bus.Busy       = (r_state == SHIFT);
endmodule

// File: tb/tb_hc595_rx.sv
// tb/tb_hc595_rx.sv - directed-vector bench for hc595_rx
import hc595_pkg::*;

module tb_hc595_rx;
    logic clk;
    logic rst_n;

    hc595_rx_if #(.BITS(16)) bus ();

    hc595_rx #(.BITS(16), .TIMEOUT(1024), .SYNC_STAGES(2)) dut (
        .Clk(clk),
        .Reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int dv_cnt = 0;
    int to_cnt = 0;
    int overlap_cnt = 0;
    logic [15:0] last_data = '0;
    logic        last_ferr = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.Data_valid) begin
                dv_cnt    <= dv_cnt + 1;
                last_data <= bus.Data_out;
                last_ferr <= bus.Frame_err;
            end
            if (bus.Timeout)
                to_cnt <= to_cnt + 1;
            if (bus.Data_valid && bus.Timeout)
                overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        bus.DS = b;
        wait_clk(2);
        bus.SHCP = 1'b1;
        wait_clk(4);
        bus.SHCP = 1'b0;
        wait_clk(2);
    endtask

    task automatic send_word(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--)
            shift_bit(w[i]);
    endtask

    task automatic latch();
        bus.STCP = 1'b1;
        wait_clk(4);
        bus.STCP = 1'b0;
        wait_clk(6);
    endtask

    task automatic latch_and_check(input string tag, input logic [15:0] exp_data,
                                   input logic exp_ferr);
        int dv0;
        dv0 = dv_cnt;
        latch();
        chk({tag, "_dv"}, dv_cnt - dv0, 1);
        chk({tag, "_data"}, last_data, exp_data);
        chk({tag, "_ferr"}, last_ferr, exp_ferr);
        chk({tag, "_busy"}, bus.Busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0, to0;
        rst_n = 1'b0;
        bus.SHCP = 1'b0;
        bus.STCP = 1'b0;
        bus.DS   = 1'b0;
        wait_clk(5);
        chk("rst_data", bus.Data_out, 0);
        chk("rst_dv", bus.Data_valid, 0);
        chk("rst_ferr", bus.Frame_err, 0);
        chk("rst_to", bus.Timeout, 0);
        chk("rst_busy", bus.Busy, 0);
        rst_n = 1'b1;
        wait_clk(4);

        send_word(16'hA5C3, 16);
        chk("t1_busy_mid", bus.Busy, 1);
        latch_and_check("t1", 16'hA5C3, 1'b0);

        // 15 ones after A5C3 (whose LSB is 1) leaves all ones
        send_word(16'h7FFF, 15);
        latch_and_check("t2_short", 16'hFFFF, 1'b1);
        send_word(16'h0001, 16);
        latch_and_check("t2_ok", 16'h0001, 1'b0);

        shift_bit(1'b1);
        send_word(16'hBEEF, 16);
        latch_and_check("t3_over", 16'hBEEF, 1'b1);

        dv0 = dv_cnt;
        to0 = to_cnt;
        send_word(16'h0016, 5);
        wait_clk(900);
        chk("t4_busy_before", bus.Busy, 1);
        chk("t4_to_early", to_cnt - to0, 0);
        wait_clk(200);
        chk("t4_to_cnt", to_cnt - to0, 1);
        chk("t4_no_dv", dv_cnt - dv0, 0);
        chk("t4_busy_after", bus.Busy, 0);
        send_word(16'h1234, 16);
        latch_and_check("t4_clean", 16'h1234, 1'b0);

        send_word(16'hFFFF, 8);
        rst_n = 1'b0;
        #3;
        chk("t5_rst_data", bus.Data_out, 0);
        chk("t5_rst_busy", bus.Busy, 0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        send_word(16'h00F0, 16);
        latch_and_check("t5", 16'h00F0, 1'b0);

        send_word(16'h5555, 16);
        dv0 = dv_cnt;
        bus.DS = 1'b1;
        wait_clk(2);
        bus.SHCP = 1'b1;
        bus.STCP = 1'b1;
        wait_clk(4);
        bus.SHCP = 1'b0;
        bus.STCP = 1'b0;
        wait_clk(4);
        chk("t6_dv", dv_cnt - dv0, 1);
        chk("t6_data", last_data, 16'h5555);
        chk("t6_ferr", last_ferr, 0);
        chk("t6_busy", bus.Busy, 1);
        // overlap bit counts as bit 1 of the next frame: 1 + 15 bits of 1ABC = 9ABC
        send_word(16'h1ABC, 15);
        latch_and_check("t6_next", 16'h9ABC, 1'b0);

        latch_and_check("t7_zero_bit", 16'h9ABC, 1'b1);

        chk("dv_to_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
